// File: rtl/im_port_arbiter.sv
// im_port_arbiter
//   Shares the single combinational read port of the instruction memory
//   between the core fetch stage (port F) and the debug reader (port D).
//   Requests are arbitrated round-robin in the cycle they are presented.
//   The granted address is driven to the memory and checked for alignment
//   and bounds. The returned word (or an error) is registered and shows up
//   on the granted port exactly one cycle later.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   f_req/f_addr/f_gnt    fetch request, byte address, accepted this cycle
//   f_rvalid/f_rdata/f_err fetch response pulse, word, error flag
//   d_req/d_addr/d_gnt    debug request, byte address, accepted this cycle
//   d_rvalid/d_rdata/d_err debug response pulse, word, error flag
//   im_addr / im_instr    address to memory / combinational word back
//   f_cnt / d_cnt         saturating per-port grant counters
//
// Handshake: a requester holds req and addr stable until it sees gnt in the
// same cycle. Dropping req before gnt withdraws the request and no response
// follows. A grant in cycle N gives rvalid for exactly cycle N+1.
module im_port_arbiter #(
    parameter int MEM_SIZE = 128,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,
    input  logic             d_req,
    input  logic [31:0]      d_addr,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    output logic [31:0]      im_addr,
    input  logic [31:0]      im_instr,
    output logic [CNT_W-1:0] f_cnt,
    output logic [CNT_W-1:0] d_cnt
);

    // Highest legal word-aligned byte address.
    localparam logic [31:0]      LAST_WORD = 32'(MEM_SIZE - 4);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             lastWasD;
    logic             grantF;
    logic             grantD;
    logic             addrErr;
    logic [31:0]      respWord;

    logic             fValidQ;
    logic             fErrQ;
    logic [31:0]      fDataQ;
    logic             dValidQ;
    logic             dErrQ;
    logic [31:0]      dDataQ;
    logic [CNT_W-1:0] fCntQ;
    logic [CNT_W-1:0] dCntQ;

    // Round-robin: on contention the port not granted last time wins.
    always_comb begin
        grantF = 1'b0;
        grantD = 1'b0;
        if (!rst) begin
            if (f_req && (!d_req || lastWasD)) begin
                grantF = 1'b1;
            end else if (d_req) begin
                grantD = 1'b1;
            end
        end
    end

    assign im_addr = grantF ? f_addr : (grantD ? d_addr : 32'h0);

    // The full 32-bit compare keeps upper-bit garbage from aliasing into
    // the memory's low address bits.
    assign addrErr  = (im_addr[1:0] != 2'b00) || (im_addr > LAST_WORD);
    assign respWord = addrErr ? 32'h0 : im_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastWasD <= 1'b1;
            fValidQ  <= 1'b0;
            fErrQ    <= 1'b0;
            fDataQ   <= 32'h0;
            dValidQ  <= 1'b0;
            dErrQ    <= 1'b0;
            dDataQ   <= 32'h0;
            fCntQ    <= '0;
            dCntQ    <= '0;
        end else begin
            fValidQ <= grantF;
            dValidQ <= grantD;
            fErrQ   <= grantF && addrErr;
            dErrQ   <= grantD && addrErr;
            if (grantF) begin
                fDataQ <= respWord;
                if (fCntQ != CNT_MAX) begin
                    fCntQ <= fCntQ + 1'b1;
                end
            end
            if (grantD) begin
                dDataQ <= respWord;
                if (dCntQ != CNT_MAX) begin
                    dCntQ <= dCntQ + 1'b1;
                end
            end
            if (grantF || grantD) begin
                lastWasD <= grantD;
            end
        end
    end

    assign f_gnt = grantF;
    assign d_gnt = grantD;

    // Reset in the cycle after a grant must squash the pending response
    // and hide the already-bumped counter, so the registered state is
    // masked while rst is high.
    assign f_rvalid = fValidQ && !rst;
    assign f_err    = fErrQ && !rst;
    assign f_rdata  = rst ? 32'h0 : fDataQ;
    assign d_rvalid = dValidQ && !rst;
    assign d_err    = dErrQ && !rst;
    assign d_rdata  = rst ? 32'h0 : dDataQ;
    assign f_cnt    = rst ? '0 : fCntQ;
    assign d_cnt    = rst ? '0 : dCntQ;

endmodule

// File: tb/tb_im_port_arbiter.sv
module tb_im_port_arbiter;

    localparam int MEM_SIZE = 128;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             f_req;
    logic [31:0]      f_addr;
    logic             f_gnt;
    logic             f_rvalid;
    logic [31:0]      f_rdata;
    logic             f_err;
    logic             d_req;
    logic [31:0]      d_addr;
    logic             d_gnt;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic             d_err;
    logic [31:0]      im_addr;
    logic [31:0]      im_instr;
    logic [CNT_W-1:0] f_cnt;
    logic [CNT_W-1:0] d_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    im_port_arbiter #(.MEM_SIZE(MEM_SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .im_addr(im_addr), .im_instr(im_instr),
        .f_cnt(f_cnt), .d_cnt(d_cnt)
    );

    // ---------------- instruction memory model ----------------
    logic [7:0] mem [0:MEM_SIZE-1];

    function automatic logic [31:0] wordAt(input logic [6:0] a);
        logic [6:0] a1, a2, a3;
        a1 = a + 7'd1;
        a2 = a + 7'd2;
        a3 = a + 7'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    always_comb im_instr = wordAt(im_addr[6:0]);

    // ---------------- checking ----------------
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected response for a granted address: {err, data}.
    function automatic logic [32:0] expResp(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a > 32'(MEM_SIZE - 4)) return {1'b1, 32'h0};
        return {1'b0, wordAt(a[6:0])};
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] fExpQ[$];
    logic [32:0] dExpQ[$];
    logic        mLastD = 1'b1;
    logic        pendF = 1'b0;
    logic        pendD = 1'b0;
    int          mFCnt = 0;
    int          mDCnt = 0;
    logic [31:0] mFData = 32'h0;
    logic [31:0] mDData = 32'h0;
    logic        gF, gD;
    logic [32:0] eF, eD;

    always @(negedge clk) begin
        // responses to last cycle's grants
        if (pendF) begin
            eF = fExpQ.pop_front();
            if (!rst) begin
                mFData = eF[31:0];
                checkVal("sb_f_err", 32'(f_err), 32'(eF[32]));
            end
        end
        if (pendD) begin
            eD = dExpQ.pop_front();
            if (!rst) begin
                mDData = eD[31:0];
                checkVal("sb_d_err", 32'(d_err), 32'(eD[32]));
            end
        end
        checkVal("sb_f_rvalid", 32'(f_rvalid), 32'(pendF && !rst));
        checkVal("sb_d_rvalid", 32'(d_rvalid), 32'(pendD && !rst));
        checkVal("sb_f_rdata", f_rdata, rst ? 32'h0 : mFData);
        checkVal("sb_d_rdata", d_rdata, rst ? 32'h0 : mDData);
        checkVal("sb_f_cnt", 32'(f_cnt), rst ? 32'h0 : 32'(mFCnt));
        checkVal("sb_d_cnt", 32'(d_cnt), rst ? 32'h0 : 32'(mDCnt));

        // this cycle's arbitration
        gF = !rst && f_req && (!d_req || mLastD);
        gD = !rst && d_req && !gF;
        checkVal("sb_f_gnt", 32'(f_gnt), 32'(gF));
        checkVal("sb_d_gnt", 32'(d_gnt), 32'(gD));
        checkVal("sb_im_addr", im_addr, gF ? f_addr : (gD ? d_addr : 32'h0));
        if (gF) begin
            fExpQ.push_back(expResp(f_addr));
            if (mFCnt < CNT_MAX) mFCnt++;
        end
        if (gD) begin
            dExpQ.push_back(expResp(d_addr));
            if (mDCnt < CNT_MAX) mDCnt++;
        end
        if (gF || gD) mLastD = gD;
        pendF = gF;
        pendD = gD;
        if (rst) begin
            mLastD = 1'b1;
            mFCnt  = 0;
            mDCnt  = 0;
            mFData = 32'h0;
            mDData = 32'h0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            6:       return {25'h0, 7'($urandom_range(0, 127))} | 32'h1;
            7:       return 32'h80 + {$urandom_range(0, 31), 2'b00};
            8:       return $urandom;
            default: return 32'h7C;
        endcase
    endfunction

    // Bound the whole run in case something stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic fg, dg;

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
        f_addr = 32'h0;
        d_addr = 32'h0;
        doReset();
        tick();

        // reset state
        @(negedge clk);
        checkVal("rst_f_cnt", 32'(f_cnt), 32'h0);
        checkVal("rst_f_rvalid", 32'(f_rvalid), 32'h0);

        // 1: single fetch of word 0
        tick();
        f_req = 1'b1; f_addr = 32'h0;
        @(negedge clk);
        checkVal("t1_f_gnt", 32'(f_gnt), 32'h1);
        checkVal("t1_im_addr", im_addr, 32'h0);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        checkVal("t1_f_rvalid", 32'(f_rvalid), 32'h1);
        checkVal("t1_f_rdata", f_rdata, 32'h8C010004);
        checkVal("t1_f_err", 32'(f_err), 32'h0);
        checkVal("t1_f_cnt", 32'(f_cnt), 32'h1);

        // 2: contention alternates starting with F
        doReset();
        f_req = 1'b1; f_addr = 32'h4;
        d_req = 1'b1; d_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("t2_f_gnt", 32'(f_gnt), 32'(i % 2 == 0));
            checkVal("t2_d_gnt", 32'(d_gnt), 32'(i % 2 == 1));
            tick();
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checkVal("t2_d_rvalid", 32'(d_rvalid), 32'h1);
        checkVal("t2_d_rdata", d_rdata, wordAt(7'h08));
        checkVal("t2_f_cnt", 32'(f_cnt), 32'h2);
        checkVal("t2_d_cnt", 32'(d_cnt), 32'h2);

        // 3: misaligned debug read
        tick();
        d_req = 1'b1; d_addr = 32'h7E;
        @(negedge clk);
        checkVal("t3_d_gnt", 32'(d_gnt), 32'h1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        checkVal("t3_d_rvalid", 32'(d_rvalid), 32'h1);
        checkVal("t3_d_err", 32'(d_err), 32'h1);
        checkVal("t3_d_rdata", d_rdata, 32'h0);

        // 4: range checks on F, back-to-back
        tick();
        f_req = 1'b1; f_addr = 32'h80;
        @(negedge clk);
        checkVal("t4_f_gnt", 32'(f_gnt), 32'h1);
        tick();
        f_addr = 32'h1000_0004;
        @(negedge clk);
        checkVal("t4_80_err", 32'(f_err), 32'h1);
        checkVal("t4_80_rdata", f_rdata, 32'h0);
        checkVal("t4_hi_im_addr", im_addr, 32'h1000_0004);
        tick();
        f_addr = 32'h7C;
        @(negedge clk);
        checkVal("t4_hi_err", 32'(f_err), 32'h1);
        checkVal("t4_hi_rdata", f_rdata, 32'h0);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        checkVal("t4_7c_err", 32'(f_err), 32'h0);
        checkVal("t4_7c_rdata", f_rdata, {mem[124], mem[125], mem[126], mem[127]});

        // 5: reset right after a grant
        doReset();
        f_req = 1'b1; f_addr = 32'h0;
        @(negedge clk);
        checkVal("t5_f_gnt", 32'(f_gnt), 32'h1);
        tick();
        f_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checkVal("t5_f_rvalid_n1", 32'(f_rvalid), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkVal("t5_f_rvalid_n2", 32'(f_rvalid), 32'h0);
        checkVal("t5_f_rdata_n2", f_rdata, 32'h0);
        checkVal("t5_f_cnt_n2", 32'(f_cnt), 32'h0);

        // 6: counter saturation
        doReset();
        f_req = 1'b1; f_addr = 32'h10;
        for (int i = 0; i < 20; i++) tick();
        f_req = 1'b0;
        @(negedge clk);
        checkVal("t6_f_cnt", 32'(f_cnt), 32'(CNT_MAX));
        checkVal("t6_d_cnt", 32'(d_cnt), 32'h0);

        // random traffic obeying the hold-until-grant rule
        doReset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            fg = f_gnt;
            dg = d_gnt;
            tick();
            rst = ($urandom_range(0, 39) == 0);
            if (!f_req || fg) begin
                f_req  = ($urandom_range(0, 2) != 0);
                f_addr = randAddr();
            end else if ($urandom_range(0, 19) == 0) begin
                f_req = 1'b0;
            end
            if (!d_req || dg) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = randAddr();
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 1'b0;
            end
        end
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
